// File: rtl/ram8_loader_pkg.sv
// Shared types and default sizes for the RAM8 burst loader.
package ram8_loader_pkg;

  localparam int unsigned DefaultWidth    = 16;
  localparam int unsigned DefaultAddrBits = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWrite  = 2'd1,
    StVerify = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/ram8_loader_if.sv
// Upstream handshake, RAM8 port and status signals of the burst loader.
interface ram8_loader_if #(
  parameter int unsigned WIDTH     = ram8_loader_pkg::DefaultWidth,
  parameter int unsigned ADDR_BITS = ram8_loader_pkg::DefaultAddrBits
);

  logic                 start;
  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS:0]   count;
  logic [WIDTH-1:0]     data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic [WIDTH-1:0]     ram_in;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_load;
  logic [WIDTH-1:0]     ram_out;
  logic                 busy;
  logic                 done;
  logic                 error;
  // Running checksum of the words accepted in the current/last burst.
  logic [WIDTH-1:0]     checksum;

  modport master (
    output start, base_addr, count, data_in, data_valid, ram_out,
    input  data_ready, ram_in, ram_addr, ram_load, busy, done, error, checksum
  );

  modport slave (
    input  start, base_addr, count, data_in, data_valid, ram_out,
    output data_ready, ram_in, ram_addr, ram_load, busy, done, error, checksum
  );

endinterface

// File: rtl/ram8.sv
// 2^ADDR_BITS x WIDTH RAM: synchronous write on load, combinational read.
module ram8
  import ram8_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned ADDR_BITS = DefaultAddrBits
) (
  input  logic                 clock,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  output logic [WIDTH-1:0]     data_out
);

  localparam int unsigned Depth = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (load) begin
      mem[address] <= data_in;
    end
  end

  assign data_out = mem[address];

endmodule

// File: rtl/ram8_checksum.sv
// WIDTH-bit wrapping accumulator with synchronous clear.
module ram8_checksum
  import ram8_loader_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] sum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clear) begin
      sum_q <= '0;
    end else if (accumulate) begin
      sum_q <= sum_q + value;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/ram8_loader.sv
// Burst loader writing upstream words into a RAM8. Define RAM8_LOADER_READBACK_EN
// to add a readback pass that compares a checksum of the RAM contents against the written data.
module ram8_loader
  import ram8_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned ADDR_BITS = DefaultAddrBits
) (
  input logic          clock,
  input logic          reset,
  ram8_loader_if.slave bus
);

  localparam int unsigned        Depth    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] MaxCount = (ADDR_BITS + 1)'(Depth);
  localparam logic [ADDR_BITS:0] CntOne   = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] AddrOne = ADDR_BITS'(1);

  state_e               state_q;
  logic [ADDR_BITS-1:0] cur_addr_q;
  logic [ADDR_BITS:0]   remaining_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 start_ok;
  logic                 handshake;
  logic [ADDR_BITS:0]   count_clamped;
  logic [WIDTH-1:0]     wr_sum;

  assign count_clamped = (bus.count > MaxCount) ? MaxCount : bus.count;
  assign start_ok      = (state_q == StIdle) && bus.start && (bus.count != '0);
  assign handshake     = (state_q == StWrite) && bus.data_valid;

  // The word lands in RAM on the same edge as the handshake.
  assign bus.data_ready = (state_q == StWrite);
  assign bus.ram_load   = handshake;
  assign bus.ram_in     = (state_q == StWrite) ? bus.data_in : '0;
  assign bus.ram_addr   = cur_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.checksum   = wr_sum;

  ram8_checksum #(
    .WIDTH(WIDTH)
  ) u_wr_sum (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .accumulate (handshake),
    .value      (bus.data_in),
    .sum        (wr_sum)
  );

`ifdef RAM8_LOADER_READBACK_EN
  logic [ADDR_BITS-1:0] base_q;
  logic [ADDR_BITS:0]   count_q;
  logic                 error_q;
  logic [WIDTH-1:0]     rd_sum;
  logic [WIDTH-1:0]     rd_final;

  ram8_checksum #(
    .WIDTH(WIDTH)
  ) u_rd_sum (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .accumulate (state_q == StVerify),
    .value      (bus.ram_out),
    .sum        (rd_sum)
  );

  // Includes the word read in the last VERIFY cycle so error is valid in DONE.
  assign rd_final  = rd_sum + bus.ram_out;
  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef RAM8_LOADER_READBACK_EN
      base_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q     <= StWrite;
            cur_addr_q  <= bus.base_addr;
            remaining_q <= count_clamped;
            busy_q      <= 1'b1;
`ifdef RAM8_LOADER_READBACK_EN
            base_q      <= bus.base_addr;
            count_q     <= count_clamped;
            error_q     <= 1'b0;
`endif
          end
        end
        StWrite: begin
          if (handshake) begin
            cur_addr_q  <= cur_addr_q + AddrOne;
            remaining_q <= remaining_q - CntOne;
            if (remaining_q == CntOne) begin
`ifdef RAM8_LOADER_READBACK_EN
              state_q     <= StVerify;
              cur_addr_q  <= base_q;
              remaining_q <= count_q;
`else
              state_q     <= StDone;
              done_q      <= 1'b1;
`endif
            end
          end
        end
`ifdef RAM8_LOADER_READBACK_EN
        StVerify: begin
          cur_addr_q  <= cur_addr_q + AddrOne;
          remaining_q <= remaining_q - CntOne;
          if (remaining_q == CntOne) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            error_q <= (rd_final != wr_sum);
          end
        end
`endif
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_loader.sv
// Self-checking bench: ram8_loader driving a real ram8, checked against an array model.
module tb_ram8_loader;
  import ram8_loader_pkg::*;

  localparam int unsigned W = DefaultWidth;
  localparam int unsigned A = DefaultAddrBits;
  localparam int unsigned D = 1 << A;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram8_loader_if #(.WIDTH(W), .ADDR_BITS(A)) bus ();

  ram8_loader #(
    .WIDTH     (W),
    .ADDR_BITS (A)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Bench-side port into the RAM, used only to corrupt a word during readback.
  logic         poke;
  logic [A-1:0] ram_a;
  logic [W-1:0] ram_d;
  logic [W-1:0] ram_q;
  logic         ram_we;
  logic [W-1:0] poke_word;

  assign poke_word   = W'(16'hFFFF);
  assign ram_a       = poke ? A'(2) : bus.ram_addr;
  assign ram_d       = poke ? poke_word : bus.ram_in;
  assign ram_we      = poke | bus.ram_load;
  assign bus.ram_out = ram_q;

  ram8 #(
    .WIDTH     (W),
    .ADDR_BITS (A)
  ) u_ram (
    .clock    (clock),
    .data_in  (ram_d),
    .load     (ram_we),
    .address  (ram_a),
    .data_out (ram_q)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_mem [D];
  logic [W-1:0] words [D];
  bit vpat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < int'(D); i++) begin
      check("ram_word", 32'(u_ram.mem[i]), 32'(model_mem[i]));
    end
  endtask

  task automatic random_words();
    for (int i = 0; i < int'(D); i++) words[i] = W'($urandom);
  endtask

  // One burst: drives the handshake with gaps from vpat (or random), ignores
  // start noise while busy, and checks every cycle against the address/word model.
  task automatic burst(input int base, input int cnt, input int gap_pct, input bit corrupt,
                       output int cycles);
    int n;
    int k;
    bit v;
    logic [W-1:0] sum;
    bit exp_err;
    n = (cnt > int'(D)) ? int'(D) : cnt;
    sum = '0;
    exp_err = 1'b0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.base_addr = A'(base);
    bus.count = (A + 1)'(cnt);
    bus.data_valid = 1'b0;
    @(negedge clock);
    check("busy_after_start", 32'(bus.busy), 32'(1));
    check("error_cleared", 32'(bus.error), 32'(0));
    k = 0;
    cycles = 0;
    while (k < n && cycles < 200) begin
      bus.start = 1'($urandom_range(1, 0));
      bus.base_addr = A'($urandom);
      bus.count = (A + 1)'($urandom);
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = ($urandom_range(99, 0) >= gap_pct);
      bus.data_valid = v;
      bus.data_in = words[k];
      #1;
      check("data_ready", 32'(bus.data_ready), 32'(1));
      check("ram_load", 32'(bus.ram_load), 32'(v));
      check("ram_addr", 32'(bus.ram_addr), 32'((base + k) % int'(D)));
      check("ram_in", 32'(bus.ram_in), 32'(words[k]));
      if (v) begin
        model_mem[(base + k) % int'(D)] = words[k];
        sum += words[k];
        k++;
      end
      cycles++;
      @(negedge clock);
    end
    if (k < n) check("write_timeout", 32'(k), 32'(n));
    bus.start = 1'b0;
    bus.data_valid = 1'b0;
`ifdef RAM8_LOADER_READBACK_EN
    for (int j = 0; j < n; j++) begin
      poke = corrupt && (j == 0);
      #1;
      check("verify_addr", 32'(bus.ram_addr), 32'((base + j) % int'(D)));
      check("verify_load", 32'(bus.ram_load), 32'(0));
      check("verify_ready", 32'(bus.data_ready), 32'(0));
      check("verify_done", 32'(bus.done), 32'(0));
      @(negedge clock);
    end
    poke = 1'b0;
    if (corrupt) begin
      model_mem[2] = poke_word;
      exp_err = 1'b1;
    end
`endif
    check("done_pulse", 32'(bus.done), 32'(1));
    check("busy_in_done", 32'(bus.busy), 32'(1));
    check("ready_in_done", 32'(bus.data_ready), 32'(0));
    check("error_in_done", 32'(bus.error), 32'(exp_err));
    check("checksum", 32'(bus.checksum), 32'(sum));
    // A start during DONE must be ignored.
    bus.start = 1'b1;
    bus.count = (A + 1)'(1);
    @(negedge clock);
    bus.start = 1'b0;
    check("done_cleared", 32'(bus.done), 32'(0));
    check("idle_busy", 32'(bus.busy), 32'(0));
    check("idle_error_held", 32'(bus.error), 32'(exp_err));
  endtask

  initial begin
    int cyc;
    int base;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.data_in = '0;
    bus.data_valid = 1'b0;
    poke = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_error", 32'(bus.error), 32'(0));
    check("rst_ready", 32'(bus.data_ready), 32'(0));
    check("rst_load", 32'(bus.ram_load), 32'(0));
    check("rst_addr", 32'(bus.ram_addr), 32'(0));
    check("rst_ram_in", 32'(bus.ram_in), 32'(0));
    check("rst_checksum", 32'(bus.checksum), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    // Full back-to-back burst of 1..8 from address 0
    for (int i = 0; i < int'(D); i++) words[i] = W'(i + 1);
    burst(0, 8, 0, 1'b0, cyc);
    check("b2b_cycles", 32'(cyc), 32'(8));
    check_mem();

    // Address wrap 6,7,0,1
    words[0] = W'(16'hAAAA);
    words[1] = W'(16'hBBBB);
    words[2] = W'(16'hCCCC);
    words[3] = W'(16'hDDDD);
    burst(6, 4, 0, 1'b0, cyc);
    check_mem();

    // Stalls: valid pattern 1,0,0,1,0,1 gives three writes over six cycles
    random_words();
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    burst(int'($urandom_range(D - 1, 0)), 3, 0, 1'b0, cyc);
    check("stall_cycles", 32'(cyc), 32'(6));
    check_mem();

    // count=0 start is ignored
    @(negedge clock);
    bus.start = 1'b1;
    bus.count = '0;
    @(negedge clock);
    check("zero_count_busy", 32'(bus.busy), 32'(0));
    check("zero_count_ready", 32'(bus.data_ready), 32'(0));
    bus.start = 1'b0;
    @(negedge clock);
    check("zero_count_idle", 32'(bus.busy), 32'(0));
    check_mem();

    // Oversized count is clamped to the RAM depth
    random_words();
    burst(int'($urandom_range(D - 1, 0)), 12, 30, 1'b0, cyc);
    check_mem();

    // Random bursts
    for (int r = 0; r < 4; r++) begin
      random_words();
      burst(int'($urandom_range(D - 1, 0)), int'($urandom_range(15, 1)), 40, 1'b0, cyc);
      check_mem();
    end

    // Reset after 2 of 5 words
    random_words();
    base = int'($urandom_range(D - 1, 0));
    @(negedge clock);
    bus.start = 1'b1;
    bus.base_addr = A'(base);
    bus.count = (A + 1)'(5);
    @(negedge clock);
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.data_valid = 1'b1;
      bus.data_in = words[k];
      model_mem[(base + k) % int'(D)] = words[k];
      @(negedge clock);
    end
    bus.data_valid = 1'b1;
    bus.data_in = words[2];
    reset = 1'b1;
    #1;
    check("abort_load", 32'(bus.ram_load), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_ready", 32'(bus.data_ready), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check("abort_addr", 32'(bus.ram_addr), 32'(0));
    check("abort_checksum", 32'(bus.checksum), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    bus.data_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("abort_no_done", 32'(bus.done), 32'(0));
      check("abort_idle", 32'(bus.busy), 32'(0));
    end
    check_mem();

`ifdef RAM8_LOADER_READBACK_EN
    // Corrupted readback flags error; a clean rerun clears it
    for (int i = 0; i < int'(D); i++) words[i] = W'(i + 1);
    burst(0, 4, 0, 1'b1, cyc);
    check_mem();
    burst(0, 4, 0, 1'b0, cyc);
    check_mem();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram8_loader.md
RAM8_LOADER -- requirements
Module: ram8_loader

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, data word width.
- REQ-002 SHALL have parameter ADDR_BITS, default 3, RAM address width (8 words).
- REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port start, input, 1, request a burst load; honoured only in IDLE.
- REQ-006 SHALL have port base_addr, input, ADDR_BITS, first RAM address of burst; sampled on accepted start.
- REQ-007 SHALL have port count, input, ADDR_BITS+1, words in burst; sampled on accepted start.
- REQ-008 SHALL have port data_in, input, WIDTH, upstream word.
- REQ-009 SHALL have port data_valid, input, 1, data_in valid.
- REQ-010 SHALL have port data_ready, output, 1, loader accepts data_in this cycle.
- REQ-011 SHALL have port ram_in, output, WIDTH, drives the RAM8 data input.
- REQ-012 SHALL have port ram_addr, output, ADDR_BITS, drives the RAM8 address.
- REQ-013 SHALL have port ram_load, output, 1, drives the RAM8 load.
- REQ-014 SHALL have port ram_out, input, WIDTH, RAM8 read data (combinational on ram_addr); used only with readback.
- REQ-015 SHALL have port busy, output, 1, high outside IDLE.
- REQ-016 SHALL have port done, output, 1, one-cycle pulse at burst end.
- REQ-017 SHALL have port error, output, 1, readback mismatch flag; held until next accepted start.

Function
- REQ-018 SHALL implement states IDLE, WRITE, VERIFY, DONE.
- REQ-019 IDLE: start=1 and count!=0 SHALL latch base_addr into cur_addr and count (clamped to 8) into remaining, clear error and checksum, and go to WRITE; count=0 SHALL ignore start.
- REQ-020 WRITE: data_ready SHALL be 1; ram_in=data_in, ram_addr=cur_addr, ram_load=data_valid, all combinational, so the word is written on the same edge as the handshake.
- REQ-021 Each handshake SHALL increment cur_addr modulo 2^ADDR_BITS (7 wraps to 0), decrement remaining, and add data_in to a WIDTH-bit wrapping checksum.
- REQ-022 Handshake with remaining=1 SHALL go to VERIFY (macro defined) or DONE (macro undefined).
- REQ-023 data_valid=0 in WRITE SHALL stall with no state change and ram_load=0.
- REQ-024 Outside WRITE, data_ready and ram_load SHALL be 0.
- REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start in DONE SHALL be ignored.
- REQ-026 start while busy SHALL be ignored.

Reset
- REQ-027 reset SHALL force IDLE asynchronously; busy, done, error, data_ready, ram_load SHALL be 0; ram_addr, ram_in, cur_addr, remaining, checksum SHALL be 0.
- REQ-028 Reset mid-burst SHALL abandon the burst; words already written stay in RAM; no done pulse.

Configuration
- REQ-029 Macro RAM8_LOADER_READBACK_EN SHALL compile in readback verification.
- REQ-030 With macro: VERIFY SHALL restart at the burst base address, drive ram_addr for one cycle per written word (ram_load=0), sum ram_out into a second checksum, then compare; mismatch SHALL set error in the DONE cycle; VERIFY SHALL last exactly count cycles.
- REQ-031 Without macro: VERIFY SHALL be unreachable, error SHALL be constant 0, ram_out SHALL be ignored.

Structure
- REQ-032 Package ram8_loader_pkg SHALL hold the state encoding and the WIDTH/ADDR_BITS defaults.
- REQ-033 The checksum adder SHALL be a sub-module ram8_checksum (accumulate, clear, WIDTH-bit wrap), instantiated twice with the macro, once without.
- REQ-034 The bench SHALL connect ram8_loader to a real RAM8 instance.

Verification
- REQ-035 base=0, count=8, data 0x0001..0x0008 back-to-back -> 8 writes in 8 cycles, RAM[i]=i+1, done 1 cycle later.
- REQ-036 base=6, count=4, data 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> RAM[6],[7],[0],[1] written; addr wrap verified.
- REQ-037 count=3, data_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, ram_load never high while data_valid=0.
- REQ-038 count=0 start, and start while busy -> no state change, no writes, busy unchanged.
- REQ-039 reset after 2 of 5 words -> immediate IDLE, ram_load=0, no done; RAM holds the 2 written words.
- REQ-040 With macro, bench corrupts RAM[2] to 0xFFFF during VERIFY of a base=0, count=4 burst -> error=1 in DONE; clean rerun -> error=0.
